// File: rtl/smi_rx_mux.sv
// smi_rx_mux: N-channel RX FIFO read-out multiplexer feeding the SMI byte path.
// A channel is chosen by fixed select or round-robin. One IQ word is pulled,
// serialised MSB-first into BYTE_W beats on valid/ready, and each beat is
// tagged with its source channel.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | waiting for i_enable and an eligible, non-empty channel
// S_PULL  | read strobe to the selected FIFO for exactly one cycle
// S_LATCH | FIFO read data is valid; capture it into the shift register
// S_SEND  | present beats; leave after the last beat is accepted
module smi_rx_mux #(
    parameter int NUM_CH = 2,
    parameter int WORD_W = 32,
    parameter int BYTE_W = 8,
    parameter int CNT_W  = 16,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     i_sys_clk,
    input  logic                     i_rst,
    input  logic                     i_enable,
    input  logic                     i_mode,
    input  logic [CH_W-1:0]          i_sel,
    input  logic [NUM_CH-1:0]        i_fifo_empty,
    output logic [NUM_CH-1:0]        o_fifo_pull,
    input  logic [NUM_CH*WORD_W-1:0] i_fifo_data,
    output logic [BYTE_W-1:0]        o_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [CH_W-1:0]          o_chan,
    output logic                     o_first,
    output logic                     o_last,
    output logic                     o_busy,
    output logic                     o_sel_err,
    output logic [CNT_W-1:0]         o_word_cnt
);

    localparam int NBEATS = WORD_W / BYTE_W;
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);
    localparam logic [CH_W:0]     NUM_CH_X  = (CH_W+1)'(NUM_CH);
    localparam logic [CH_W-1:0]   MAX_CH    = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {S_IDLE, S_PULL, S_LATCH, S_SEND} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [NUM_CH-1:0]   r_pull;
    logic [WORD_W-1:0]   r_shift;
    logic [BEAT_W-1:0]   r_beat;
    logic                r_valid;
    logic                r_first;
    logic                r_last;
    logic                r_busy;
    logic [CH_W-1:0]     r_chan;
    logic [CH_W-1:0]     r_rr_ptr;
    logic [CNT_W-1:0]    r_word_cnt;

    logic                w_sel_ok;
    logic                w_fixed_ok;
    logic                w_rr_found;
    logic [CH_W-1:0]     w_rr_ch;
    logic [CH_W:0]       w_idx;
    logic [CH_W-1:0]     w_pick;
    logic                w_pick_ok;
    logic                w_start;
    logic [NUM_CH-1:0]   w_pull_hot;
    logic [WORD_W-1:0]   w_word;
    logic                w_accept;
    logic                w_last_acc;
    logic [CH_W-1:0]     w_rr_next;
    logic [BEAT_W-1:0]   w_beat_nxt;

    // The wide compare keeps i_sel range-checking correct for non power-of-two channel counts.
    assign w_sel_ok   = ({1'b0, i_sel} < NUM_CH_X);
    assign o_sel_err  = !i_mode && !w_sel_ok;
    assign w_fixed_ok = w_sel_ok && !i_fifo_empty[i_sel];

    // Round-robin search: first non-empty channel at or above the pointer, wrapping.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_ch    = '0;
        w_idx      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_idx = {1'b0, r_rr_ptr} + (CH_W+1)'(i);
            if (w_idx >= NUM_CH_X) begin
                w_idx = w_idx - NUM_CH_X;
            end
            if (!w_rr_found && !i_fifo_empty[w_idx[CH_W-1:0]]) begin
                w_rr_found = 1'b1;
                w_rr_ch    = w_idx[CH_W-1:0];
            end
        end
    end

    assign w_pick     = i_mode ? w_rr_ch : i_sel;
    assign w_pick_ok  = i_mode ? w_rr_found : w_fixed_ok;
    assign w_start    = i_enable && w_pick_ok;
    assign w_pull_hot = NUM_CH'(1) << w_pick;
    assign w_accept   = r_valid && i_ready;
    assign w_last_acc = w_accept && r_last;
    assign w_rr_next  = (r_chan == MAX_CH) ? '0 : r_chan + 1'b1;
    assign w_beat_nxt = r_beat + 1'b1;

    // Select the FIFO read-data slice of the latched channel.
    always_comb begin
        w_word = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_chan == CH_W'(k)) begin
                w_word = i_fifo_data[k*WORD_W +: WORD_W];
            end
        end
    end

    // State register.
    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; mode/select/enable only matter in S_IDLE so a word always completes.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_PULL;
            S_PULL:  w_state_nxt = S_LATCH;
            S_LATCH: w_state_nxt = S_SEND;
            S_SEND:  if (w_last_acc) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Registered datapath and outputs: pull strobe, shift register, beat flags, counters.
    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pull     <= '0;
            r_shift    <= '0;
            r_beat     <= '0;
            r_valid    <= 1'b0;
            r_first    <= 1'b0;
            r_last     <= 1'b0;
            r_busy     <= 1'b0;
            r_chan     <= '0;
            r_rr_ptr   <= '0;
            r_word_cnt <= '0;
        end else begin
            r_pull <= '0;
            r_busy <= (w_state_nxt != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_chan <= w_pick;
                        r_pull <= w_pull_hot;
                    end
                end
                S_LATCH: begin
                    r_shift <= w_word;
                    r_beat  <= '0;
                    r_valid <= 1'b1;
                    r_first <= 1'b1;
                    r_last  <= (NBEATS == 1);
                end
                S_SEND: begin
                    if (w_accept) begin
                        r_shift <= r_shift << BYTE_W;
                        r_beat  <= w_beat_nxt;
                        r_first <= 1'b0;
                        r_last  <= (w_beat_nxt == LAST_BEAT);
                        if (r_last) begin
                            r_valid    <= 1'b0;
                            r_last     <= 1'b0;
                            r_beat     <= '0;
                            r_word_cnt <= r_word_cnt + 1'b1;
                            r_rr_ptr   <= w_rr_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_fifo_pull = r_pull;
    assign o_data      = r_shift[WORD_W-1 -: BYTE_W];
    assign o_valid     = r_valid;
    assign o_chan      = r_chan;
    assign o_first     = r_first;
    assign o_last      = r_last;
    assign o_busy      = r_busy;
    assign o_word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_smi_rx_mux.sv
// Directed bench for smi_rx_mux with three channels and a 4-bit word counter.
module tb_smi_rx_mux;

    localparam int NUM_CH = 3;
    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;
    localparam int CNT_W  = 4;
    localparam int CH_W   = 2;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     i_enable = 1'b0;
    logic                     i_mode = 1'b0;
    logic [CH_W-1:0]          i_sel = '0;
    logic [NUM_CH-1:0]        fifo_empty;
    logic [NUM_CH-1:0]        o_fifo_pull;
    logic [NUM_CH*WORD_W-1:0] fifo_data = '0;
    logic [BYTE_W-1:0]        o_data;
    logic                     o_valid;
    logic                     i_ready = 1'b0;
    logic [CH_W-1:0]          o_chan;
    logic                     o_first;
    logic                     o_last;
    logic                     o_busy;
    logic                     o_sel_err;
    logic [CNT_W-1:0]         o_word_cnt;

    int checks = 0;
    int failures = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    // FIFO model: read data appears the cycle after a pull
    logic [31:0] mem [NUM_CH][64];
    int wp [NUM_CH] = '{0, 0, 0};
    int rp [NUM_CH] = '{0, 0, 0};
    int cyc = 0;

    // beat / pull log
    logic [7:0]  lg_data[$];
    logic [1:0]  lg_chan[$];
    logic        lg_first[$];
    logic        lg_last[$];
    int          lg_cyc[$];
    logic [2:0]  lg_pull[$];
    int          pull_cyc[$];

    always #5 clk = ~clk;

    smi_rx_mux #(
        .NUM_CH(NUM_CH), .WORD_W(WORD_W), .BYTE_W(BYTE_W), .CNT_W(CNT_W)
    ) dut (
        .i_sys_clk(clk), .i_rst(rst), .i_enable(i_enable), .i_mode(i_mode),
        .i_sel(i_sel), .i_fifo_empty(fifo_empty), .o_fifo_pull(o_fifo_pull),
        .i_fifo_data(fifo_data), .o_data(o_data), .o_valid(o_valid),
        .i_ready(i_ready), .o_chan(o_chan), .o_first(o_first), .o_last(o_last),
        .o_busy(o_busy), .o_sel_err(o_sel_err), .o_word_cnt(o_word_cnt)
    );

    always_comb begin
        fifo_empty = '0;
        for (int k = 0; k < NUM_CH; k++) fifo_empty[k] = (wp[k] == rp[k]);
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (o_fifo_pull[k] && (wp[k] != rp[k])) begin
                fifo_data[k*32 +: 32] <= mem[k][rp[k]];
                rp[k] <= rp[k] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (o_fifo_pull != 3'b000) begin
                lg_pull.push_back(o_fifo_pull);
                pull_cyc.push_back(cyc);
            end
            if (o_valid && i_ready) begin
                lg_data.push_back(o_data);
                lg_chan.push_back(o_chan);
                lg_first.push_back(o_first);
                lg_last.push_back(o_last);
                lg_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int ch, input logic [31:0] w);
        mem[ch][wp[ch]] = w;
        wp[ch] = wp[ch] + 1;
    endtask

    task automatic clear_log();
        lg_data.delete(); lg_chan.delete(); lg_first.delete();
        lg_last.delete(); lg_cyc.delete(); lg_pull.delete(); pull_cyc.delete();
    endtask

    task automatic wait_beats(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk);
            #1;
            if (lg_data.size() >= n) ok = 1'b1;
        end
    endtask

    function automatic logic [31:0] word_at(input int j);
        return {lg_data[4*j], lg_data[4*j+1], lg_data[4*j+2], lg_data[4*j+3]};
    endfunction

    task automatic test_reset();
        step(2);
        checks++;
        if ({o_fifo_pull, o_valid, o_data, o_chan, o_first, o_last} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got pull=%b valid=%b data=%h chan=%0d first=%b last=%b expected all zero",
                     o_fifo_pull, o_valid, o_data, o_chan, o_first, o_last);
        end
        checks++;
        if (o_busy !== 1'b0 || o_word_cnt !== 4'd0) begin
            failures++;
            $display("FAIL reset_busy_cnt: got busy=%b cnt=%0d expected 0 0", o_busy, o_word_cnt);
        end
        checks++;
        if (o_sel_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_sel_err: got %b expected 0", o_sel_err);
        end
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_fixed();
        bit ok;
        clear_log();
        i_mode = 1'b0; i_sel = 2'd1; i_ready = 1'b1;
        push(1, 32'hA1B2C3D4);
        i_enable = 1'b1;
        wait_beats(4, 30, ok);
        i_enable = 1'b0;
        step(3);
        exp_cnt = exp_cnt + 1'b1;
        checks++;
        if (!ok) begin failures++; $display("FAIL fixed_timeout: got %0d beats expected 4", lg_data.size()); end
        checks++;
        if (word_at(0) !== 32'hA1B2C3D4) begin failures++; $display("FAIL fixed_word: got %h expected a1b2c3d4", word_at(0)); end
        checks++;
        if ({lg_first[0], lg_first[1], lg_first[2], lg_first[3]} !== 4'b1000 ||
            {lg_last[0], lg_last[1], lg_last[2], lg_last[3]} !== 4'b0001) begin
            failures++;
            $display("FAIL fixed_flags: got first=%b%b%b%b last=%b%b%b%b expected 1000 0001",
                     lg_first[0], lg_first[1], lg_first[2], lg_first[3], lg_last[0], lg_last[1], lg_last[2], lg_last[3]);
        end
        checks++;
        if ({lg_chan[0], lg_chan[1], lg_chan[2], lg_chan[3]} !== 8'b01010101) begin
            failures++; $display("FAIL fixed_chan: got %0d expected 1 on all beats", lg_chan[0]);
        end
        checks++;
        if (lg_pull.size() != 1 || lg_pull[0] !== 3'b010) begin
            failures++; $display("FAIL fixed_pull: got %0d pulls first=%b expected 1 pull 010", lg_pull.size(), lg_pull[0]);
        end
        checks++;
        if (lg_cyc[0] - pull_cyc[0] != 2) begin
            failures++; $display("FAIL fixed_latency: got %0d cycles expected 2", lg_cyc[0] - pull_cyc[0]);
        end
        checks++;
        if (o_word_cnt !== exp_cnt || o_busy !== 1'b0) begin
            failures++; $display("FAIL fixed_cnt: got cnt=%0d busy=%b expected cnt=%0d busy=0", o_word_cnt, o_busy, exp_cnt);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [31:0] exp_w [6] = '{32'h0A0B0C01, 32'h1B1C1D11, 32'h0A0B0C02,
                                   32'h1B1C1D12, 32'h0A0B0C03, 32'h1B1C1D13};
        clear_log();
        push(0, 32'h0A0B0C01); push(0, 32'h0A0B0C02); push(0, 32'h0A0B0C03);
        push(1, 32'h1B1C1D11); push(1, 32'h1B1C1D12); push(1, 32'h1B1C1D13);
        i_mode = 1'b1; i_ready = 1'b1; i_enable = 1'b1;
        wait_beats(24, 80, ok);
        i_enable = 1'b0;
        step(3);
        exp_cnt = exp_cnt + 4'd6;
        checks++;
        if (!ok) begin failures++; $display("FAIL rr_timeout: got %0d beats expected 24", lg_data.size()); end
        for (int j = 0; j < 6; j++) begin
            checks++;
            if (word_at(j) !== exp_w[j] || lg_chan[4*j] !== 2'(j % 2)) begin
                failures++;
                $display("FAIL rr_word%0d: got %h ch%0d expected %h ch%0d", j, word_at(j), lg_chan[4*j], exp_w[j], j % 2);
            end
        end
        for (int j = 1; j < 6; j++) begin
            checks++;
            if (pull_cyc[j] - pull_cyc[j-1] != 7) begin
                failures++; $display("FAIL rr_spacing%0d: got %0d cycles expected 7", j, pull_cyc[j] - pull_cyc[j-1]);
            end
        end
        checks++;
        if (o_word_cnt !== exp_cnt) begin failures++; $display("FAIL rr_cnt: got %0d expected %0d", o_word_cnt, exp_cnt); end
    endtask

    task automatic test_rr_single();
        bit ok;
        clear_log();
        push(0, 32'h33000001); push(0, 32'h33000002); push(0, 32'h33000003);
        i_mode = 1'b1; i_ready = 1'b1; i_enable = 1'b1;
        wait_beats(12, 50, ok);
        i_enable = 1'b0;
        step(3);
        exp_cnt = exp_cnt + 4'd3;
        checks++;
        if (!ok || lg_pull.size() != 3) begin
            failures++; $display("FAIL rr_single_count: got %0d beats %0d pulls expected 12 3", lg_data.size(), lg_pull.size());
        end
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (lg_pull[j] !== 3'b001 || word_at(j) !== 32'h33000001 + j) begin
                failures++; $display("FAIL rr_single_word%0d: got pull=%b word=%h expected 001 %h", j, lg_pull[j], word_at(j), 32'h33000001 + j);
            end
        end
        checks++;
        if (o_word_cnt !== exp_cnt) begin failures++; $display("FAIL rr_single_cnt: got %0d expected %0d", o_word_cnt, exp_cnt); end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit stalled;
        logic [9:0] snap;
        logic pat [11] = '{1, 0, 0, 1, 0, 0, 1, 0, 1, 1, 1};
        clear_log();
        i_mode = 1'b0; i_sel = 2'd0; i_ready = 1'b0;
        push(0, 32'h11223344);
        i_enable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (o_valid) ok = 1'b1;
        end
        i_enable = 1'b0;
        checks++;
        if (!ok) begin failures++; $display("FAIL bp_valid_timeout: got valid=%b expected 1", o_valid); end
        snap = {o_data, o_first, o_last};
        stalled = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(posedge clk);
            #1;
            i_ready = pat[i];
            @(negedge clk);
            if (o_valid && stalled) begin
                checks++;
                if ({o_data, o_first, o_last} !== snap) begin
                    failures++; $display("FAIL bp_stable%0d: got %h expected %h", i, {o_data, o_first, o_last}, snap);
                end
            end
            snap = {o_data, o_first, o_last};
            stalled = o_valid && !i_ready;
        end
        i_ready = 1'b1;
        step(5);
        exp_cnt = exp_cnt + 1'b1;
        checks++;
        if (lg_data.size() != 4 || word_at(0) !== 32'h11223344) begin
            failures++; $display("FAIL bp_beats: got %0d beats word=%h expected 4 11223344", lg_data.size(), word_at(0));
        end
        checks++;
        if ({lg_first[0], lg_first[1], lg_first[2], lg_first[3], lg_last[0], lg_last[1], lg_last[2], lg_last[3]} !== 8'b1000_0001) begin
            failures++; $display("FAIL bp_flags: got first=%b last=%b expected 1 on first/last beat", lg_first[0], lg_last[3]);
        end
        checks++;
        if (lg_pull.size() != 1 || o_word_cnt !== exp_cnt) begin
            failures++; $display("FAIL bp_pull_cnt: got %0d pulls cnt=%0d expected 1 %0d", lg_pull.size(), o_word_cnt, exp_cnt);
        end
    endtask

    task automatic test_enable_drop();
        bit ok;
        clear_log();
        push(2, 32'hCAFEF00D); push(2, 32'h12345678);
        i_mode = 1'b0; i_sel = 2'd2; i_ready = 1'b1; i_enable = 1'b1;
        wait_beats(2, 30, ok);
        i_enable = 1'b0;
        step(15);
        exp_cnt = exp_cnt + 1'b1;
        checks++;
        if (!ok || lg_data.size() != 4 || word_at(0) !== 32'hCAFEF00D) begin
            failures++; $display("FAIL en_drop_word: got %0d beats word=%h expected 4 cafef00d", lg_data.size(), word_at(0));
        end
        checks++;
        if (o_busy !== 1'b0 || lg_pull.size() != 1 || (wp[2] - rp[2]) != 1) begin
            failures++; $display("FAIL en_drop_idle: got busy=%b pulls=%0d left=%0d expected 0 1 1", o_busy, lg_pull.size(), wp[2] - rp[2]);
        end
        checks++;
        if (o_word_cnt !== exp_cnt) begin failures++; $display("FAIL en_drop_cnt: got %0d expected %0d", o_word_cnt, exp_cnt); end
    endtask

    task automatic test_sel_err();
        bit ok;
        i_enable = 1'b0; i_mode = 1'b1; i_sel = 2'd3;
        #1;
        checks++;
        if (o_sel_err !== 1'b0) begin failures++; $display("FAIL sel_err_rr: got %b expected 0", o_sel_err); end
        i_mode = 1'b0;
        #1;
        checks++;
        if (o_sel_err !== 1'b1) begin failures++; $display("FAIL sel_err_fixed: got %b expected 1", o_sel_err); end
        clear_log();
        i_ready = 1'b1; i_enable = 1'b1;
        step(20);
        checks++;
        if (lg_pull.size() != 0 || o_busy !== 1'b0 || o_sel_err !== 1'b1) begin
            failures++; $display("FAIL sel_err_hold: got pulls=%0d busy=%b err=%b expected 0 0 1", lg_pull.size(), o_busy, o_sel_err);
        end
        i_sel = 2'd2;
        wait_beats(4, 30, ok);
        i_enable = 1'b0;
        step(3);
        exp_cnt = exp_cnt + 1'b1;
        checks++;
        if (!ok || word_at(0) !== 32'h12345678 || lg_chan[0] !== 2'd2 || lg_pull[0] !== 3'b100) begin
            failures++; $display("FAIL sel_err_resume: got word=%h ch=%0d pull=%b expected 12345678 2 100", word_at(0), lg_chan[0], lg_pull[0]);
        end
        checks++;
        if (o_sel_err !== 1'b0 || o_word_cnt !== exp_cnt) begin
            failures++; $display("FAIL sel_err_after: got err=%b cnt=%0d expected 0 %0d", o_sel_err, o_word_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_mid_word();
        bit ok;
        clear_log();
        push(0, 32'hA1B2C3D4); push(0, 32'h55667788);
        i_mode = 1'b0; i_sel = 2'd0; i_ready = 1'b1; i_enable = 1'b1;
        wait_beats(2, 30, ok);
        checks++;
        if (!ok || o_data !== 8'hC3 || o_valid !== 1'b1) begin
            failures++; $display("FAIL rst_mid_pre: got data=%h valid=%b expected c3 1", o_data, o_valid);
        end
        rst = 1'b1;
        #1;
        exp_cnt = '0;
        checks++;
        if (o_valid !== 1'b0 || o_word_cnt !== 4'd0 || o_busy !== 1'b0 || o_data !== 8'h00 || o_fifo_pull !== 3'b000) begin
            failures++;
            $display("FAIL rst_mid_outputs: got valid=%b cnt=%0d busy=%b data=%h pull=%b expected all zero",
                     o_valid, o_word_cnt, o_busy, o_data, o_fifo_pull);
        end
        step(2);
        clear_log();
        rst = 1'b0;
        wait_beats(4, 30, ok);
        i_enable = 1'b0;
        step(3);
        exp_cnt = exp_cnt + 1'b1;
        checks++;
        if (!ok || word_at(0) !== 32'h55667788 || lg_first[0] !== 1'b1 || lg_first[1] !== 1'b0) begin
            failures++; $display("FAIL rst_mid_next: got word=%h first=%b%b expected 55667788 10", word_at(0), lg_first[0], lg_first[1]);
        end
        checks++;
        if (lg_pull.size() != 1 || o_word_cnt !== exp_cnt) begin
            failures++; $display("FAIL rst_mid_cnt: got pulls=%0d cnt=%0d expected 1 %0d", lg_pull.size(), o_word_cnt, exp_cnt);
        end
    endtask

    task automatic test_cnt_wrap();
        bit ok;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
        clear_log();
        for (int j = 0; j < 17; j++) push(1, 32'h70000000 + j);
        i_mode = 1'b0; i_sel = 2'd1; i_ready = 1'b1; i_enable = 1'b1;
        wait_beats(68, 17 * 7 + 40, ok);
        i_enable = 1'b0;
        step(3);
        checks++;
        if (!ok || lg_pull.size() != 17) begin
            failures++; $display("FAIL wrap_count: got %0d beats %0d pulls expected 68 17", lg_data.size(), lg_pull.size());
        end
        checks++;
        if (word_at(16) !== 32'h70000010) begin failures++; $display("FAIL wrap_last_word: got %h expected 70000010", word_at(16)); end
        checks++;
        if (o_word_cnt !== 4'd1) begin failures++; $display("FAIL wrap_cnt: got %0d expected 1", o_word_cnt); end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_round_robin();
        test_rr_single();
        test_backpressure();
        test_enable_drop();
        test_sel_err();
        test_reset_mid_word();
        test_cnt_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
